// File: rtl/f_fetch_reg.sv
// f_fetch_reg: fetch stage of the five-stage pipeline.
// Holds the program counter, drives the instruction-memory address and latches
// the fetched word into the F/D pipeline register consumed by decode.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   stall        hazard stall; freezes the PC and the F/D register
//   flush        clears the F/D register to a bubble (wins over stall)
//   redirect     take redirect_pc as the next PC (ignored while stalled)
//   redirect_pc  branch / j / jr target
//   F_pc         current PC, instruction-memory address
//   F_instr      instruction-memory read data for F_pc (combinational ROM)
//   D_instr      latched instruction (forced to 0 on a fetch error)
//   D_pc         PC of D_instr
//   D_imm16      D_instr[15:0], feeds the immediate extender
//   D_valid      F/D register holds a real fetch
//   D_adel       fetch address error for the instruction in D
module f_fetch_reg #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] F_pc,
    input  logic [31:0] F_instr,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc,
    output logic [15:0] D_imm16,
    output logic        D_valid,
    output logic        D_adel
);

    logic [31:0] r_pc;
    logic [31:0] r_d_instr;
    logic [31:0] r_d_pc;
    logic        r_d_valid;
    logic        r_d_adel;

    logic [31:0] w_npc;
    logic        w_ferr;

    // Wraps mod 2^32 by construction of the 32-bit add.
    assign w_npc  = redirect ? redirect_pc : r_pc + 32'd4;
    assign w_ferr = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) || (r_pc > IM_LIMIT);

    // A redirect during a stall is dropped: the redirecting instruction is
    // itself held in D and will assert it again once released.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= PC_RESET;
        end else if (!stall) begin
            r_pc <= w_npc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_d_instr <= 32'h0;
            r_d_pc    <= 32'h0;
            r_d_valid <= 1'b0;
            r_d_adel  <= 1'b0;
        end else if (!stall) begin
            r_d_instr <= w_ferr ? 32'h0 : F_instr;
            r_d_pc    <= r_pc;
            r_d_valid <= 1'b1;
            r_d_adel  <= w_ferr;
        end
    end

    assign F_pc    = r_pc;
    assign D_instr = r_d_instr;
    assign D_pc    = r_d_pc;
    assign D_imm16 = r_d_instr[15:0];
    assign D_valid = r_d_valid;
    assign D_adel  = r_d_adel;

endmodule

// File: tb/tb_f_fetch_reg.sv
module tb_f_fetch_reg;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] F_pc;
    logic [31:0] F_instr;
    logic [31:0] D_instr;
    logic [31:0] D_pc;
    logic [15:0] D_imm16;
    logic        D_valid;
    logic        D_adel;

    int total = 0;
    int bad   = 0;

    f_fetch_reg dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .F_pc       (F_pc),
        .F_instr    (F_instr),
        .D_instr    (D_instr),
        .D_pc       (D_pc),
        .D_imm16    (D_imm16),
        .D_valid    (D_valid),
        .D_adel     (D_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ROM: one distinctive word at 0x3000, elsewhere an
    // addiu-like word carrying the low half of the address.
    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h3C01_1234;
        return {16'h2400, a[15:0]};
    endfunction

    assign F_instr = rom(F_pc);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks F_pc and every D field; instr is given explicitly (0 for bubbles/errors).
    task automatic chk_all(input string tag, input logic [31:0] fpc, input logic [31:0] dpc,
                           input logic [31:0] dinstr, input logic dvalid, input logic dadel);
        chk({tag, ".F_pc"}, F_pc, fpc);
        chk({tag, ".D_pc"}, D_pc, dpc);
        chk({tag, ".D_instr"}, D_instr, dinstr);
        chk({tag, ".D_imm16"}, {16'h0, D_imm16}, {16'h0, dinstr[15:0]});
        chk({tag, ".D_valid"}, {31'h0, D_valid}, {31'h0, dvalid});
        chk({tag, ".D_adel"}, {31'h0, D_adel}, {31'h0, dadel});
    endtask

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        step();
        step();
        chk_all("reset", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0);

        // Free run from reset.
        reset = 1'b0;
        step();
        chk_all("first", 32'h3004, 32'h3000, 32'h3C01_1234, 1'b1, 1'b0);
        step();
        chk_all("run1", 32'h3008, 32'h3004, 32'h2400_3004, 1'b1, 1'b0);
        step();
        step();
        chk_all("run3", 32'h3010, 32'h300C, 32'h2400_300C, 1'b1, 1'b0);
        step();
        chk_all("branch_in_d", 32'h3014, 32'h3010, 32'h2400_3010, 1'b1, 1'b0);

        // Redirect with delay slot.
        redirect    = 1'b1;
        redirect_pc = 32'h3100;
        step();
        chk_all("redir", 32'h3100, 32'h3014, 32'h2400_3014, 1'b1, 1'b0);
        redirect = 1'b0;
        step();
        chk_all("target", 32'h3104, 32'h3100, 32'h2400_3100, 1'b1, 1'b0);

        // Stall 3 cycles with a redirect that must be ignored.
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h3200;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("stall", 32'h3104, 32'h3100, 32'h2400_3100, 1'b1, 1'b0);
        end
        stall    = 1'b0;
        redirect = 1'b0;
        step();
        chk_all("unstall", 32'h3108, 32'h3104, 32'h2400_3104, 1'b1, 1'b0);

        // Flush together with stall.
        stall = 1'b1;
        flush = 1'b1;
        step();
        chk_all("flush_stall", 32'h3108, 32'h0, 32'h0, 1'b0, 1'b0);
        stall = 1'b0;
        flush = 1'b0;
        step();
        chk_all("refetch", 32'h310C, 32'h3108, 32'h2400_3108, 1'b1, 1'b0);

        // Misaligned fetch.
        redirect    = 1'b1;
        redirect_pc = 32'h3102;
        step();
        chk_all("to_3102", 32'h3102, 32'h310C, 32'h2400_310C, 1'b1, 1'b0);
        // Out-of-range fetch redirected while the misaligned one enters D.
        redirect_pc = 32'h7000;
        step();
        chk_all("misalign", 32'h7000, 32'h3102, 32'h0, 1'b1, 1'b1);
        redirect_pc = 32'h3000;
        step();
        chk_all("above_lim", 32'h3000, 32'h7000, 32'h0, 1'b1, 1'b1);
        redirect = 1'b0;
        step();
        chk_all("recover", 32'h3004, 32'h3000, 32'h3C01_1234, 1'b1, 1'b0);

        // Upper limit is inclusive, one word past it is an error.
        redirect    = 1'b1;
        redirect_pc = 32'h6FFC;
        step();
        redirect = 1'b0;
        step();
        chk_all("at_limit", 32'h7000, 32'h6FFC, 32'h2400_6FFC, 1'b1, 1'b0);

        // Just below the base.
        redirect    = 1'b1;
        redirect_pc = 32'h2FFC;
        step();
        redirect = 1'b0;
        step();
        chk_all("below_base", 32'h3000, 32'h2FFC, 32'h0, 1'b1, 1'b1);

        // Wrap-around of the PC add.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        step();
        chk_all("wrap_a", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b1);
        step();
        chk_all("wrap_b", 32'h4, 32'h0, 32'h0, 1'b1, 1'b1);

        // Reset mid-stream with every other control asserted.
        reset       = 1'b1;
        stall       = 1'b1;
        flush       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h3200;
        step();
        chk_all("mid_reset", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0);
        reset    = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        redirect = 1'b0;
        step();
        chk_all("post_reset", 32'h3004, 32'h3000, 32'h3C01_1234, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
